fpu_round_stage: RTL and testbench

Final stage of the single-precision add/sub pipeline. Consumes the normalized result (sign, biased exponent, 24-bit mantissa with hidden bit, 3 guard bits, special-case flags, rounding mode) from the add normalize step. Applies IEEE-754 rounding under the RISC-V rounding modes and emits the packed binary32 result plus exception flags. Two-stage stallable pipeline with valid/ready handshakes on both sides.

---
 rtl/fpu_pkg.sv | 12 +
 rtl/fpu_round_pkg.sv | 57 +++++
 rtl/fpu_pipe_reg.sv | 45 ++++
 rtl/fpu_round_stage.sv | 126 ++++++++++++
 tb/tb_fpu_round_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions used across the floating-point pipeline.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fpu_round_mode_t;

endpackage

// File: rtl/fpu_round_pkg.sv
// Types, constants and helpers for the binary32 rounding stage.
package fpu_round_pkg;
  import fpu_pkg::*;

  localparam logic [31:0] FPU_MAX_FINITE = 32'h7F7FFFFF;
  localparam logic [31:0] FPU_POS_INF    = 32'h7F800000;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_flags_t;

  typedef struct packed {
    logic            sign;
    logic [7:0]      exponent;
    logic [23:0]     mantissa;
    logic            inc;
    logic            inexact;
    fpu_round_mode_t mode;
    logic            nan;
    logic            inf;
  } fpu_round_s1_t;

  // guard = {guard, round, sticky}
  function automatic logic fpu_round_increment(input logic sign, input logic lsb,
                                               input logic [2:0] guard,
                                               input fpu_round_mode_t mode);
    logic inexact;
    logic inc;
    inexact = |guard;
    case (mode)
      RM_RNE:  inc = guard[2] & (guard[1] | guard[0] | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = guard[2];
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  function automatic logic [31:0] fpu_round_overflow_value(input logic sign,
                                                           input fpu_round_mode_t mode);
    logic [31:0] mag;
    case (mode)
      RM_RTZ:  mag = FPU_MAX_FINITE;
      RM_RDN:  mag = sign ? FPU_POS_INF : FPU_MAX_FINITE;
      RM_RUP:  mag = sign ? FPU_MAX_FINITE : FPU_POS_INF;
      default: mag = FPU_POS_INF;
    endcase
    return {sign, mag[30:0]};
  endfunction

endpackage

// File: rtl/fpu_pipe_reg.sv
// Stallable register slice with valid/ready; holds data while downstream stalls.
module fpu_pipe_reg #(
  parameter int DATA_W   = 32,
  parameter bit RST_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en;

  assign en        = !vld_q || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q;
  assign out_data  = data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush)   vld_d = 1'b0;
    else if (en) vld_d = in_valid;
    if (en && in_valid) data_d = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      if (RST_DATA) data_q <= '0;
      else          data_q <= data_d;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fpu_round_stage.sv
// IEEE-754 binary32 rounding stage for the add/sub pipeline: increment decision,
// then apply/pack with overflow, underflow and inexact flags.
module fpu_round_stage
  import fpu_pkg::*;
  import fpu_round_pkg::*;
#(
  parameter logic [31:0] CANONICAL_NAN       = 32'h7FC00000,
  parameter bit          ILLEGAL_MODE_AS_RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exponent,
  input  logic [23:0] in_mantissa,
  input  logic [2:0]  in_guard,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_zero,
  input  logic [2:0]  in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags
);

  localparam int S1_W = $bits(fpu_round_s1_t);
  localparam int S2_W = 32 + $bits(fpu_flags_t);

  fpu_round_s1_t   s1_in, s1_p1;
  fpu_round_mode_t mode_eff;
  logic [S1_W-1:0] s1_in_bits, s1_bits;
  logic [S2_W-1:0] s2_in_bits, s2_bits;
  logic            vld_p1, rdy_p2;
  logic            unused_zero;

  // Zero operands need no special handling: mantissa/exponent already encode them.
  assign unused_zero = in_zero;

  // Stage 1: increment decision
  always_comb begin
    mode_eff = fpu_round_mode_t'(in_mode);
    if (in_mode > 3'd4) mode_eff = ILLEGAL_MODE_AS_RNE ? RM_RNE : RM_RTZ;
    s1_in.sign     = in_sign;
    s1_in.exponent = in_exponent;
    s1_in.mantissa = in_mantissa;
    s1_in.inc      = fpu_round_increment(in_sign, in_mantissa[0], in_guard, mode_eff);
    s1_in.inexact  = |in_guard;
    s1_in.mode     = mode_eff;
    s1_in.nan      = in_nan;
    s1_in.inf      = in_inf;
  end

  assign s1_in_bits = s1_in;
  assign s1_p1      = s1_bits;

  fpu_pipe_reg #(.DATA_W(S1_W), .RST_DATA(1'b0)) u_pipe_p1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_bits),
    .out_valid (vld_p1),
    .out_ready (rdy_p2),
    .out_data  (s1_bits)
  );

  // Stage 2: apply increment, renormalize, pack
  logic [24:0]  sum;
  logic [23:0]  man;
  logic [8:0]   exp9;
  logic         ovf;
  logic [31:0]  res;
  fpu_flags_t   flg;

  always_comb begin
    sum  = {1'b0, s1_p1.mantissa} + {24'd0, s1_p1.inc};
    man  = sum[23:0];
    exp9 = {1'b0, s1_p1.exponent};
    if (sum[24]) begin
      man  = 24'h800000;
      exp9 = exp9 + 9'd1;
    end
    // Hidden bit decides normal vs subnormal; a subnormal that rounds up becomes exp 1.
    if (man[23]) begin
      if (exp9 == 9'd0) exp9 = 9'd1;
    end else begin
      exp9 = 9'd0;
    end
    ovf = (exp9 >= 9'd255);
    flg = '0;
    if (s1_p1.nan) begin
      res = CANONICAL_NAN;
    end else if (s1_p1.inf) begin
      res = {s1_p1.sign, 8'hFF, 23'd0};
    end else if (ovf) begin
      res    = fpu_round_overflow_value(s1_p1.sign, s1_p1.mode);
      flg.of = 1'b1;
      flg.nx = 1'b1;
    end else begin
      res    = {s1_p1.sign, exp9[7:0], man[22:0]};
      flg.uf = (exp9 == 9'd0) & s1_p1.inexact;
      flg.nx = s1_p1.inexact;
    end
    s2_in_bits = {res, flg};
  end

  fpu_pipe_reg #(.DATA_W(S2_W), .RST_DATA(1'b1)) u_pipe_p2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p2),
    .in_data   (s2_in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_bits)
  );

  assign out_result = s2_bits[S2_W-1:5];
  assign out_flags  = s2_bits[4:0];

endmodule

// File: tb/tb_fpu_round_stage.sv
// Scoreboard bench for fpu_round_stage: directed vectors, random ops against an
// arithmetic reference model, backpressure, flush and reset behaviour.
module tb_fpu_round_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        in_sign, in_nan, in_inf, in_zero;
  logic [7:0]  in_exponent;
  logic [23:0] in_mantissa;
  logic [2:0]  in_guard, in_mode;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic [36:0] exp_q[$];
  string       name_q[$];
  logic [36:0] mon_exp;
  string       mon_nm;

  always #5 clk = ~clk;

  fpu_round_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
    .in_guard(in_guard), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  // Reference: treat {mantissa, guard} as a value in eighths of an ulp and round it.
  function automatic logic [36:0] model(input logic s, input logic [7:0] e,
                                        input logic [23:0] m, input logic [2:0] g,
                                        input logic nn, input logic nf, input logic [2:0] md);
    int          rm, ex;
    int unsigned mag, eighths;
    bit          inexact, up, toward_inf;
    logic [31:0] r;
    logic [4:0]  f;
    rm = (md > 3'd4) ? 0 : int'(md);
    eighths = 32'(g);
    inexact = (eighths != 0);
    case (rm)
      0:       up = (eighths > 4) || (eighths == 4 && (m % 2) == 1);
      1:       up = 1'b0;
      2:       up = s && inexact;
      3:       up = !s && inexact;
      default: up = (eighths >= 4);
    endcase
    mag = 32'(m) + 32'(up);
    ex  = int'(e);
    if (mag == 32'h1000000) begin
      mag = 32'h800000;
      ex  = ex + 1;
    end
    if (mag >= 32'h800000) begin
      if (ex == 0) ex = 1;
    end else begin
      ex = 0;
    end
    if (nn) return {32'h7FC00000, 5'b00000};
    if (nf) return {s, 8'hFF, 23'h0, 5'b00000};
    if (ex >= 255) begin
      toward_inf = (rm == 0) || (rm == 4) || (rm == 2 && s) || (rm == 3 && !s);
      r = toward_inf ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
      f = 5'b00101;
    end else begin
      r = {s, ex[7:0], mag[22:0]};
      f = {3'b000, (ex == 0) && inexact, inexact};
    end
    return {r, f};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per accepted output.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got result %h flags %b, expected none", out_result, out_flags);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = name_q.pop_front();
        if ({out_result, out_flags} !== mon_exp) begin
          fails++;
          $display("FAIL %s: got result %h flags %b, expected result %h flags %b",
                   mon_nm, out_result, out_flags, mon_exp[36:5], mon_exp[4:0]);
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the op was accepted.
  task automatic issue(input logic s, input logic [7:0] e, input logic [23:0] m,
                       input logic [2:0] g, input logic nn, input logic nf,
                       input logic [2:0] md, input logic [36:0] expv, input string nm);
    int waited = 0;
    bit done = 0;
    in_sign = s; in_exponent = e; in_mantissa = m; in_guard = g;
    in_nan = nn; in_inf = nf; in_zero = (m == 24'd0); in_mode = md;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expv);
        name_q.push_back(nm);
        done = 1;
      end else if (waited > 200) begin
        tests++; fails++;
        $display("FAIL %s_accept_timeout: in_ready stuck at 0, expected 1", nm);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic issue_dir(input logic s, input logic [7:0] e, input logic [23:0] m,
                           input logic [2:0] g, input logic nn, input logic nf,
                           input logic [2:0] md, input logic [31:0] r,
                           input logic [4:0] f, input string nm);
    issue(s, e, m, g, nn, nf, md, {r, f}, nm);
  endtask

  task automatic issue_rand(input string nm);
    logic [7:0]  e;
    logic [23:0] m;
    logic [2:0]  g, md;
    logic        s, nn, nf;
    case ($urandom_range(0, 6))
      0: e = 8'd0;
      1: e = 8'd254;
      2: e = 8'd255;
      3: e = 8'd127;
      default: e = 8'($urandom_range(0, 255));
    endcase
    m = 24'($urandom);
    m[23] = (e != 8'd0);
    if ($urandom_range(0, 7) == 0) m = (e != 8'd0) ? 24'hFFFFFF : 24'h7FFFFF;
    g  = 3'($urandom_range(0, 7));
    md = 3'($urandom_range(0, 7));
    s  = 1'($urandom_range(0, 1));
    nn = ($urandom_range(0, 19) == 0);
    nf = ($urandom_range(0, 19) == 0);
    issue(s, e, m, g, nn, nf, md, model(s, e, m, g, nn, nf, md), nm);
  endtask

  task automatic drain(input string nm);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_stall;
    bit rand_done;
    int lat;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 0; in_exponent = 0; in_mantissa = 0; in_guard = 0;
    in_nan = 0; in_inf = 0; in_zero = 0; in_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_result", 64'(out_result), 64'd0);
    check("reset_out_flags", 64'(out_flags), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed vectors with hand-derived results
    issue_dir(0, 8'd127, 24'h800001, 3'b100, 0, 0, 3'd0, 32'h3F800002, 5'b00001, "rne_tie_odd");
    issue_dir(0, 8'd127, 24'h800000, 3'b100, 0, 0, 3'd0, 32'h3F800000, 5'b00001, "rne_tie_even");
    issue_dir(0, 8'd127, 24'hFFFFFF, 3'b110, 0, 0, 3'd0, 32'h40000000, 5'b00001, "carry_renorm");
    issue_dir(0, 8'd254, 24'hFFFFFF, 3'b110, 0, 0, 3'd0, 32'h7F800000, 5'b00101, "carry_overflow");
    issue_dir(0, 8'd255, 24'h800000, 3'b000, 0, 0, 3'd1, 32'h7F7FFFFF, 5'b00101, "ovf_rtz_pos");
    issue_dir(1, 8'd255, 24'h800000, 3'b000, 0, 0, 3'd3, 32'hFF7FFFFF, 5'b00101, "ovf_rup_neg");
    issue_dir(1, 8'd255, 24'h800000, 3'b000, 0, 0, 3'd2, 32'hFF800000, 5'b00101, "ovf_rdn_neg");
    issue_dir(0, 8'd0,   24'h7FFFFF, 3'b111, 0, 0, 3'd3, 32'h00800000, 5'b00001, "sub_to_normal");
    issue_dir(0, 8'd0,   24'h000001, 3'b001, 0, 0, 3'd0, 32'h00000001, 5'b00011, "sub_underflow");
    issue_dir(1, 8'd254, 24'hFFFFFF, 3'b111, 1, 1, 3'd3, 32'h7FC00000, 5'b00000, "nan_canon");
    issue_dir(1, 8'd12,  24'h812345, 3'b101, 0, 1, 3'd0, 32'hFF800000, 5'b00000, "inf_neg");
    issue_dir(0, 8'd127, 24'h800001, 3'b100, 0, 0, 3'd6, 32'h3F800002, 5'b00001, "illegal_mode6");
    issue_dir(1, 8'd0,   24'h000000, 3'b000, 0, 0, 3'd0, 32'h80000000, 5'b00000, "neg_exact_zero");
    issue_dir(0, 8'd100, 24'hABCDEF, 3'b100, 0, 0, 3'd4, 32'h322BCDF0, 5'b00001, "rmm_tie");
    drain("directed");

    // Latency with an empty pipeline
    issue_dir(0, 8'd127, 24'h800000, 3'b000, 0, 0, 3'd0, 32'h3F800000, 5'b00000, "latency_op");
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      @(posedge clk); #1;
    end
    check("latency_cycles", 64'(lat), 64'd2);
    @(posedge clk); #1;
    drain("latency");

    // Backpressure: 6 ops while the output stalls for 4 cycles
    saw_stall = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) issue_rand($sformatf("bp_op%0d", i));
      end
      begin
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        repeat (8) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1;
        end
      end
    join
    check("bp_in_ready_fell", 64'(saw_stall), 64'd1);
    drain("backpressure");

    // Flush: in-flight op dropped, the next accepted op appears two cycles later
    mon_en = 1'b0;
    @(posedge clk); #1;
    in_sign = 0; in_exponent = 8'd127; in_mantissa = 24'h800001; in_guard = 3'b000;
    in_nan = 0; in_inf = 0; in_mode = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_mantissa = 24'h800002; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_sign = 1; in_exponent = 8'd255; in_mantissa = 24'h800000; in_mode = 3'd3;
    @(negedge clk);
    check("flush_out_valid_next", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid_c3", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("flush_out_valid_c4", 64'(out_valid), 64'd1);
    check("flush_next_result", {27'd0, out_result, out_flags},
          {27'd0, model(1, 8'd255, 24'h800000, 3'b000, 0, 0, 3'd3)});
    @(posedge clk); #1;

    // Reset while stalled
    out_ready = 1'b0;
    issue_rand("rst_op0");
    issue_rand("rst_op1");
    exp_q.delete();
    name_q.delete();
    @(negedge clk);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall_out_valid", 64'(out_valid), 64'd0);
    check("rst_stall_out_result", 64'(out_result), 64'd0);
    check("rst_stall_out_flags", 64'(out_flags), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    mon_en = 1'b1;

    // Random stream with random output backpressure and input gaps
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          issue_rand($sformatf("rand_op%0d", i));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
